mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port RAM arbiter between the icache and dcache of up to two CPUs. It sits between the cache layer and the RAM model. It grants exactly one of up to four requesters (CPUn dcache, CPUn icache) at a time and drives the RAM port from the granted requester. It holds every other requester in wait until the RAM reports completion.

## Interface
Parameters:
- CPUS, 2: number of CPUs served (1 or 2); requester ports are CPUS-wide vectors / arrays.

Ports (word = 32 bits):
- clk  in  1  system clock
- nRST  in  1  asynchronous, active-low reset
- iREN  in  CPUS  icache read request per CPU
- iaddr  in  CPUS x 32  icache word address per CPU
- dREN  in  CPUS  dcache read request per CPU
- dWEN  in  CPUS  dcache write request per CPU
- daddr  in  CPUS x 32  dcache address per CPU
- dstore  in  CPUS x 32  dcache write data per CPU
- iwait  out  CPUS  icache stall; low for exactly the completing cycle
- dwait  out  CPUS  dcache stall; low for exactly the completing cycle
- iload  out  CPUS x 32  read data, ramload broadcast
- dload  out  CPUS x 32  read data, ramload broadcast
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3
- memerr  out  1  sticky; set on any ERROR during a grant

## Operation
- State machine: IDLE, ACTIVE. Registers: state, owner {cpu, isdata}, rr_last (last served CPU), memerr.
- IDLE:
  - ram enables are 0; all waits are 1.
  - If any request is pending, latch the winner into owner and go to ACTIVE.
  - If no request is pending, stay in IDLE.
- Winner scan: CPUs in order starting at (rr_last+1) mod CPUS. Within a CPU, the dcache (dREN|dWEN) wins over the icache (iREN).
- ACTIVE, owner is dcache:
  - ramaddr=daddr[cpu].
  - If dWEN=1: ramWEN=1, ramREN=0, ramstore=dstore[cpu].
  - If dWEN=0: ramREN=1.
  - If dWEN and dREN are both high, the access is a write.
- ACTIVE, owner is icache: ramaddr=iaddr[cpu], ramREN=1, ramstore=0.
- Completion: ramstate==ACCESS in ACTIVE.
  - The owner's wait goes low in that same cycle (combinational).
  - rr_last<=owner.cpu; next state IDLE.
- Abort: the owner's request drops while in ACTIVE. Go to IDLE next cycle, no ack, rr_last unchanged; RAM enables follow the dropped request that cycle.
- ERROR: ramstate==ERROR in ACTIVE sets memerr=1 and returns to IDLE with no ack. The requester re-arbitrates if it still requests.
- Requesters must hold address, data and enables stable until their wait is low. The arbiter does not latch addresses; it muxes live inputs.
- Non-owners always see wait=1 while in ACTIVE.
- One-cycle IDLE bubble between grants is mandatory. A requester still asserted in the cycle after its ack re-arbitrates as a new request.

## Timing
- Reset: state=IDLE, owner=0, rr_last=CPUS-1 (so CPU0 scans first), memerr=0. Outputs: ramREN=ramWEN=0, ramaddr=ramstore=0, all iwait/dwait=1. iload/dload follow ramload.
- Request sampled in cycle 0 (IDLE) → RAM enables asserted in cycle 1 → ack in the first cycle with ramstate==ACCESS (cycle 1 at the earliest) → IDLE the cycle after the ack.
- Minimum request-to-ack latency: 1 cycle. Back-to-back throughput: one access per 2 cycles plus RAM latency.
- A new request arriving while in ACTIVE waits; it is scanned on the next IDLE cycle.
- nRST asserted mid-ACTIVE: everything returns to reset values immediately (async). The transaction is dropped and no ack is given.
- CPUS=1: rr_last is a constant 0; the dcache-over-icache rule alone decides the winner.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined: the inter-CPU scan starts at (rr_last+1) mod CPUS, and rr_last updates on each completion.
- Undefined: fixed priority. CPU0 is always scanned first, and rr_last is neither implemented nor updated.
- The dcache-over-icache rule applies in both builds.

## Test plan
- Single icache read: CPU0 iREN=1, iaddr=0x40; RAM returns ACCESS with ramload=0xDEADBEEF on the 2nd ACTIVE cycle → ramREN=1 and ramaddr=0x40 from cycle 1; iwait[0]=0 only in the ACCESS cycle; iload[0]=0xDEADBEEF.
- Intra-CPU priority: CPU0 iREN and dWEN (daddr=0x80, dstore=0x1234) both high → the write is served first (ramWEN=1, ramstore=0x1234). The icache read is served only after the IDLE bubble.
- Round-robin (macro on): CPU0 and CPU1 dREN held continuously, RAM always ACCESS → grants alternate CPU0, CPU1, CPU0, each 2 cycles apart. With the macro off, CPU0 wins every time.
- Abort: CPU1 iREN drops in ACTIVE while ramstate=BUSY → IDLE next cycle, iwait[1] stays 1, rr_last unchanged.
- Error: ramstate=ERROR during an owned read → memerr=1 (sticky), no wait deasserted. A still-asserted request is re-granted after IDLE.
- Reset mid-ACTIVE: pull nRST low while ramREN=1 → ramREN=0 and all waits=1 immediately. The first grant after reset goes to CPU0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between the icache/dcache of up to CPUS CPUs.
// Latency: request seen in IDLE, RAM enables next cycle, ack in first ACCESS cycle, one IDLE bubble after.
// Backpressure: every non-owner is held with wait=1; the owner's wait drops only in its completing cycle.
//
// Ports:
//   clk, nRST                      clock, asynchronous active-low reset
//   iREN/iaddr                     icache read request + word address per CPU
//   dREN/dWEN/daddr/dstore         dcache read/write request, address, write data per CPU
//   iwait/dwait                    per-CPU stalls, low for exactly the completing cycle
//   iload/dload                    ramload broadcast to every CPU
//   ramREN/ramWEN/ramaddr/ramstore RAM port, driven live from the owning requester
//   ramload/ramstate               RAM read data and status (FREE, BUSY, ACCESS, ERROR)
//   memerr                         sticky flag, set on ERROR during a grant
//
// Build option: define MEM_ARB_ROUND_ROBIN_EN for round-robin between CPUs;
// otherwise CPU0 is always scanned first. dcache beats icache within a CPU in both builds.

module mem_arbiter #(
    parameter int CPUS = 2
) (
    input  logic                   clk,
    input  logic                   nRST,
    input  logic [CPUS-1:0]        iREN,
    input  logic [CPUS-1:0][31:0]  iaddr,
    input  logic [CPUS-1:0]        dREN,
    input  logic [CPUS-1:0]        dWEN,
    input  logic [CPUS-1:0][31:0]  daddr,
    input  logic [CPUS-1:0][31:0]  dstore,
    output logic [CPUS-1:0]        iwait,
    output logic [CPUS-1:0]        dwait,
    output logic [CPUS-1:0][31:0]  iload,
    output logic [CPUS-1:0][31:0]  dload,
    output logic                   ramREN,
    output logic                   ramWEN,
    output logic [31:0]            ramaddr,
    output logic [31:0]            ramstore,
    input  logic [31:0]            ramload,
    input  logic [1:0]             ramstate,
    output logic                   memerr
);

    localparam int CW = (CPUS > 1) ? $clog2(CPUS) : 1;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] own_cpu_q, own_cpu_d;
    logic          own_data_q, own_data_d;
    logic          memerr_q, memerr_d;

    logic          win_vld;
    logic          win_data;
    logic [CW-1:0] win_cpu;

    logic          sel_iren, sel_dren, sel_dwen;
    logic [31:0]   sel_iaddr, sel_daddr, sel_dstore;

    logic          active;
    logic          own_req;
    logic          ack;
    logic          ram_err;
    int            scan_start;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [CW-1:0] rr_last_q, rr_last_d;

    // Scan begins with the CPU after the one served last.
    assign scan_start = (int'(rr_last_q) + 1) % CPUS;
`else
    assign scan_start = 0;
`endif

    // Winner scan. Positions are visited from last to first so that the
    // earliest position in scan order is the final (winning) assignment.
    always_comb begin
        win_vld  = 1'b0;
        win_cpu  = '0;
        win_data = 1'b0;
        for (int k = CPUS - 1; k >= 0; k--) begin
            for (int c = 0; c < CPUS; c++) begin
                if ((c == (scan_start + k) % CPUS) && (dREN[c] || dWEN[c] || iREN[c])) begin
                    win_vld  = 1'b1;
                    win_cpu  = CW'(c);
                    win_data = dREN[c] || dWEN[c];
                end
            end
        end
    end

    // Live mux of the owning CPU's request lines; nothing is latched.
    always_comb begin
        sel_iren   = 1'b0;
        sel_dren   = 1'b0;
        sel_dwen   = 1'b0;
        sel_iaddr  = '0;
        sel_daddr  = '0;
        sel_dstore = '0;
        for (int c = 0; c < CPUS; c++) begin
            if (own_cpu_q == CW'(c)) begin
                sel_iren   = iREN[c];
                sel_dren   = dREN[c];
                sel_dwen   = dWEN[c];
                sel_iaddr  = iaddr[c];
                sel_daddr  = daddr[c];
                sel_dstore = dstore[c];
            end
        end
    end

    assign active  = (state_q == ST_ACTIVE);
    assign own_req = own_data_q ? (sel_dren || sel_dwen) : sel_iren;
    assign ack     = active && own_req && (ramstate == RS_ACCESS);
    assign ram_err = active && (ramstate == RS_ERROR);

    // RAM port follows the owner's live request, so an abort cycle
    // already shows the dropped enables.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        if (active) begin
            if (own_data_q) begin
                ramaddr  = sel_daddr;
                ramWEN   = sel_dwen;
                ramREN   = sel_dren && !sel_dwen;
                ramstore = sel_dwen ? sel_dstore : 32'h0;
            end else begin
                ramaddr  = sel_iaddr;
                ramREN   = sel_iren;
            end
        end
    end

    always_comb begin
        iwait = '1;
        dwait = '1;
        for (int c = 0; c < CPUS; c++) begin
            if (ack && (own_cpu_q == CW'(c))) begin
                if (own_data_q) begin
                    dwait[c] = 1'b0;
                end else begin
                    iwait[c] = 1'b0;
                end
            end
        end
    end

    assign iload  = {CPUS{ramload}};
    assign dload  = {CPUS{ramload}};
    assign memerr = memerr_q;

    always_comb begin
        state_d    = state_q;
        own_cpu_d  = own_cpu_q;
        own_data_d = own_data_q;
        memerr_d   = memerr_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        rr_last_d  = rr_last_q;
`endif
        if (!active) begin
            if (win_vld) begin
                state_d    = ST_ACTIVE;
                own_cpu_d  = win_cpu;
                own_data_d = win_data;
            end
        end else begin
            if (ram_err) begin
                memerr_d = 1'b1;
            end
            if (ack) begin
                state_d = ST_IDLE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                rr_last_d = own_cpu_q;
`endif
            end else if (!own_req || ram_err) begin
                // Abort or RAM error: release without ack, fairness pointer untouched.
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q    <= ST_IDLE;
            own_cpu_q  <= '0;
            own_data_q <= 1'b0;
            memerr_q   <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            rr_last_q  <= CW'(CPUS - 1);
`endif
        end else begin
            state_q    <= state_d;
            own_cpu_q  <= own_cpu_d;
            own_data_q <= own_data_d;
            memerr_q   <= memerr_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            rr_last_q  <= rr_last_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed vector table, corner-case sequences,
// and randomized traffic compared against a transaction-level model.

module tb_mem_arbiter;

    localparam int CPUS = 2;

    logic                  clk = 1'b0;
    logic                  nRST;
    logic [CPUS-1:0]       iREN, dREN, dWEN;
    logic [CPUS-1:0][31:0] iaddr, daddr, dstore;
    logic [CPUS-1:0]       iwait, dwait;
    logic [CPUS-1:0][31:0] iload, dload;
    logic                  ramREN, ramWEN;
    logic [31:0]           ramaddr, ramstore, ramload;
    logic [1:0]            ramstate;
    logic                  memerr;

    always #5 clk = ~clk;

    mem_arbiter #(.CPUS(CPUS)) dut (
        .clk(clk), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .memerr(memerr)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0]  ir, dr, dw, rs;
        logic        er, ew;
        logic [31:0] ea, es;
        logic [1:0]  eiw, edw;
        logic        em;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    // Reference model state: the current grant (if any) at transaction level.
    bit m_busy, m_data, m_err;
    int m_cpu, m_last;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_outs(input string tg, input logic er, input logic ew,
                            input logic [31:0] ea, input logic [31:0] es,
                            input logic [1:0] eiw, input logic [1:0] edw, input logic em);
        chk({tg, ".ramREN"},   32'(ramREN),  32'(er));
        chk({tg, ".ramWEN"},   32'(ramWEN),  32'(ew));
        chk({tg, ".ramaddr"},  ramaddr,      ea);
        chk({tg, ".ramstore"}, ramstore,     es);
        chk({tg, ".iwait"},    32'(iwait),   32'(eiw));
        chk({tg, ".dwait"},    32'(dwait),   32'(edw));
        chk({tg, ".memerr"},   32'(memerr),  32'(em));
        for (int c = 0; c < CPUS; c++) begin
            chk({tg, ".iload"}, iload[c], ramload);
            chk({tg, ".dload"}, dload[c], ramload);
        end
    endtask

    task automatic drive(input logic [1:0] ir, input logic [1:0] dr,
                         input logic [1:0] dw, input logic [1:0] rs);
        iREN = ir; dREN = dr; dWEN = dw; ramstate = rs;
    endtask

    // One clock cycle: inputs change 1ns after the edge, outputs sampled 4ns later.
    task automatic step(input logic [1:0] ir, input logic [1:0] dr,
                        input logic [1:0] dw, input logic [1:0] rs);
        @(posedge clk);
        #1;
        drive(ir, dr, dw, rs);
        #4;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        drive(2'b00, 2'b00, 2'b00, 2'd0);
        nRST = 1'b0;
        @(posedge clk);
        #1;
        nRST = 1'b1;
    endtask

    task automatic model_reset();
        m_busy = 0; m_data = 0; m_err = 0; m_cpu = 0; m_last = CPUS - 1;
    endtask

    // Pick a requester from the rules: CPU order, dcache before icache.
    task automatic model_pick();
        for (int k = 0; k < CPUS; k++) begin
            int c;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            c = (m_last + 1 + k) % CPUS;
`else
            c = k;
`endif
            if (!m_busy && (dREN[c] || dWEN[c])) begin
                m_busy = 1; m_cpu = c; m_data = 1;
            end else if (!m_busy && iREN[c]) begin
                m_busy = 1; m_cpu = c; m_data = 0;
            end
        end
    endtask

    logic [31:0] g2_addr;
    logic [1:0]  g2_dw, abort_next_dw;
    logic [31:0] abort_next_addr;

    initial begin
        nRST     = 1'b0;
        drive(2'b00, 2'b00, 2'b00, 2'd0);
        iaddr    = {32'h0000_0140, 32'h0000_0040};
        daddr    = {32'h0000_0180, 32'h0000_0080};
        dstore   = {32'h0000_5678, 32'h0000_1234};
        ramload  = 32'hDEAD_BEEF;

        //                ir     dr     dw     rs    er ew  ea          es          eiw    edw    em
        vecs[0]  = '{2'b00, 2'b00, 2'b00, 2'd0, 0, 0, 32'h0,   32'h0,    2'b11, 2'b11, 0};
        vecs[1]  = '{2'b01, 2'b00, 2'b00, 2'd0, 0, 0, 32'h0,   32'h0,    2'b11, 2'b11, 0};
        vecs[2]  = '{2'b01, 2'b00, 2'b00, 2'd1, 1, 0, 32'h40,  32'h0,    2'b11, 2'b11, 0};
        vecs[3]  = '{2'b01, 2'b00, 2'b00, 2'd2, 1, 0, 32'h40,  32'h0,    2'b10, 2'b11, 0};
        vecs[4]  = '{2'b00, 2'b00, 2'b00, 2'd0, 0, 0, 32'h0,   32'h0,    2'b11, 2'b11, 0};
        vecs[5]  = '{2'b01, 2'b00, 2'b01, 2'd0, 0, 0, 32'h0,   32'h0,    2'b11, 2'b11, 0};
        vecs[6]  = '{2'b01, 2'b00, 2'b01, 2'd2, 0, 1, 32'h80,  32'h1234, 2'b11, 2'b10, 0};
        vecs[7]  = '{2'b01, 2'b00, 2'b00, 2'd0, 0, 0, 32'h0,   32'h0,    2'b11, 2'b11, 0};
        vecs[8]  = '{2'b01, 2'b00, 2'b00, 2'd2, 1, 0, 32'h40,  32'h0,    2'b10, 2'b11, 0};
        vecs[9]  = '{2'b00, 2'b00, 2'b00, 2'd0, 0, 0, 32'h0,   32'h0,    2'b11, 2'b11, 0};
        vecs[10] = '{2'b10, 2'b00, 2'b00, 2'd0, 0, 0, 32'h0,   32'h0,    2'b11, 2'b11, 0};
        vecs[11] = '{2'b10, 2'b00, 2'b00, 2'd1, 1, 0, 32'h140, 32'h0,    2'b11, 2'b11, 0};
        vecs[12] = '{2'b00, 2'b00, 2'b00, 2'd1, 0, 0, 32'h140, 32'h0,    2'b11, 2'b11, 0};
        vecs[13] = '{2'b00, 2'b00, 2'b00, 2'd2, 0, 0, 32'h0,   32'h0,    2'b11, 2'b11, 0};
        vecs[14] = '{2'b00, 2'b01, 2'b00, 2'd0, 0, 0, 32'h0,   32'h0,    2'b11, 2'b11, 0};
        vecs[15] = '{2'b00, 2'b01, 2'b00, 2'd3, 1, 0, 32'h80,  32'h0,    2'b11, 2'b11, 0};
        vecs[16] = '{2'b00, 2'b01, 2'b00, 2'd0, 0, 0, 32'h0,   32'h0,    2'b11, 2'b11, 1};
        vecs[17] = '{2'b00, 2'b01, 2'b00, 2'd2, 1, 0, 32'h80,  32'h0,    2'b11, 2'b10, 1};
        vecs[18] = '{2'b00, 2'b00, 2'b00, 2'd0, 0, 0, 32'h0,   32'h0,    2'b11, 2'b11, 1};

        // Reset state while nRST is held low.
        #3;
        chk_outs("reset", 0, 0, 32'h0, 32'h0, 2'b11, 2'b11, 0);
        @(posedge clk);
        #1;
        nRST = 1'b1;

        // Directed vector table.
        for (int i = 0; i < NV; i++) begin
            step(vecs[i].ir, vecs[i].dr, vecs[i].dw, vecs[i].rs);
            chk_outs($sformatf("vec%0d", i), vecs[i].er, vecs[i].ew, vecs[i].ea,
                     vecs[i].es, vecs[i].eiw, vecs[i].edw, vecs[i].em);
        end

        // Both dcaches held, RAM always ready: grants every 2 cycles.
`ifdef MEM_ARB_ROUND_ROBIN_EN
        g2_addr = 32'h180; g2_dw = 2'b01;
`else
        g2_addr = 32'h80;  g2_dw = 2'b10;
`endif
        do_reset();
        step(2'b00, 2'b11, 2'b00, 2'd2);
        chk_outs("rr_idle0", 0, 0, 32'h0, 32'h0, 2'b11, 2'b11, 0);
        step(2'b00, 2'b11, 2'b00, 2'd2);
        chk_outs("rr_grant1", 1, 0, 32'h80, 32'h0, 2'b11, 2'b10, 0);
        step(2'b00, 2'b11, 2'b00, 2'd2);
        chk_outs("rr_idle1", 0, 0, 32'h0, 32'h0, 2'b11, 2'b11, 0);
        step(2'b00, 2'b11, 2'b00, 2'd2);
        chk_outs("rr_grant2", 1, 0, g2_addr, 32'h0, 2'b11, g2_dw, 0);
        step(2'b00, 2'b11, 2'b00, 2'd2);
        chk_outs("rr_idle2", 0, 0, 32'h0, 32'h0, 2'b11, 2'b11, 0);
        step(2'b00, 2'b11, 2'b00, 2'd2);
        chk_outs("rr_grant3", 1, 0, 32'h80, 32'h0, 2'b11, 2'b10, 0);

        // Abort must leave the fairness pointer where the last completion put it.
`ifdef MEM_ARB_ROUND_ROBIN_EN
        abort_next_addr = 32'h180; abort_next_dw = 2'b01;
`else
        abort_next_addr = 32'h80;  abort_next_dw = 2'b10;
`endif
        do_reset();
        step(2'b01, 2'b00, 2'b00, 2'd0);
        step(2'b01, 2'b00, 2'b00, 2'd2);
        chk_outs("ab_ack0", 1, 0, 32'h40, 32'h0, 2'b10, 2'b11, 0);
        step(2'b10, 2'b00, 2'b00, 2'd0);
        step(2'b10, 2'b00, 2'b00, 2'd1);
        chk_outs("ab_own1", 1, 0, 32'h140, 32'h0, 2'b11, 2'b11, 0);
        step(2'b00, 2'b00, 2'b00, 2'd1);
        chk_outs("ab_drop", 0, 0, 32'h140, 32'h0, 2'b11, 2'b11, 0);
        step(2'b00, 2'b11, 2'b00, 2'd0);
        chk_outs("ab_idle", 0, 0, 32'h0, 32'h0, 2'b11, 2'b11, 0);
        step(2'b00, 2'b11, 2'b00, 2'd2);
        chk_outs("ab_next", 1, 0, abort_next_addr, 32'h0, 2'b11, abort_next_dw, 0);

        // Asynchronous reset in the middle of a grant.
        do_reset();
        step(2'b10, 2'b00, 2'b00, 2'd1);
        step(2'b10, 2'b00, 2'b00, 2'd1);
        chk_outs("mr_active", 1, 0, 32'h140, 32'h0, 2'b11, 2'b11, 0);
        #1;
        nRST = 1'b0;
        #1;
        chk_outs("mr_reset", 0, 0, 32'h0, 32'h0, 2'b11, 2'b11, 0);
        drive(2'b00, 2'b00, 2'b00, 2'd0);
        @(posedge clk);
        #1;
        nRST = 1'b1;
        step(2'b10, 2'b01, 2'b00, 2'd0);
        chk_outs("mr_idle", 0, 0, 32'h0, 32'h0, 2'b11, 2'b11, 0);
        step(2'b10, 2'b01, 2'b00, 2'd2);
        chk_outs("mr_first", 1, 0, 32'h80, 32'h0, 2'b11, 2'b10, 0);

        // Randomized traffic against the transaction-level model.
        do_reset();
        model_reset();
        for (int n = 0; n < 600; n++) begin
            logic        alive, done, e_ren, e_wen;
            logic [31:0] e_addr, e_store;
            logic [1:0]  e_iw, e_dw;
            int          r;
            @(posedge clk);
            #1;
            for (int c = 0; c < CPUS; c++) begin
                if ($urandom_range(5) == 0) iREN[c] = ~iREN[c];
                if ($urandom_range(5) == 0) dREN[c] = ~dREN[c];
                if ($urandom_range(7) == 0) dWEN[c] = ~dWEN[c];
                iaddr[c]  = $urandom();
                daddr[c]  = $urandom();
                dstore[c] = $urandom();
            end
            r = int'($urandom_range(15));
            ramstate = (r == 0) ? 2'd3 : (r <= 6) ? 2'd2 : (r <= 11) ? 2'd1 : 2'd0;
            ramload  = $urandom();
            #4;

            alive = m_busy && (m_data ? (dREN[m_cpu] || dWEN[m_cpu]) : iREN[m_cpu]);
            done  = alive && (ramstate == 2'd2);
            e_ren = 0; e_wen = 0; e_addr = 0; e_store = 0; e_iw = 2'b11; e_dw = 2'b11;
            if (m_busy && m_data) begin
                e_addr  = daddr[m_cpu];
                e_wen   = dWEN[m_cpu];
                e_ren   = dREN[m_cpu] && !dWEN[m_cpu];
                e_store = dWEN[m_cpu] ? dstore[m_cpu] : 32'h0;
                if (done) e_dw[m_cpu] = 1'b0;
            end else if (m_busy) begin
                e_addr = iaddr[m_cpu];
                e_ren  = iREN[m_cpu];
                if (done) e_iw[m_cpu] = 1'b0;
            end
            chk_outs($sformatf("rnd%0d", n), e_ren, e_wen, e_addr, e_store, e_iw, e_dw, m_err);

            if (!m_busy) begin
                model_pick();
            end else begin
                if (ramstate == 2'd3) m_err = 1;
                if (done) begin
                    m_busy = 0;
                    m_last = m_cpu;
                end else if (!alive || ramstate == 2'd3) begin
                    m_busy = 0;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
